// File: rtl/dac_wave_gen_pkg.sv
// Shared definitions for dac_wave_gen: FSM state encoding, waveform select codes
// and the non-sine waveform mapping from a 12-bit phase.
package dac_wave_gen_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_PULSE = 3'd2;
  localparam logic [2:0] ST_ACK   = 3'd3;
  localparam logic [2:0] ST_HOLD  = 3'd4;

  typedef enum logic [1:0] {
    WAVE_SAW  = 2'b00,
    WAVE_TRI  = 2'b01,
    WAVE_SQR  = 2'b10,
    WAVE_SINE = 2'b11
  } wave_sel_e;

  localparam logic [11:0] MIDSCALE = 12'h800;

  // sine_val carries either the LUT result or midscale, depending on the build.
  function automatic logic [11:0] wave_map(input logic [1:0]  sel,
                                           input logic [11:0] phase,
                                           input logic [11:0] sine_val);
    logic [11:0] w_res;
    case (sel)
      WAVE_SAW: w_res = phase;
      WAVE_TRI: w_res = phase[11] ? ~{phase[10:0], 1'b0} : {phase[10:0], 1'b0};
      WAVE_SQR: w_res = phase[11] ? 12'hFFF : 12'h000;
      default:  w_res = sine_val;
    endcase
    return w_res;
  endfunction

endpackage

// File: rtl/dac_wave_gen_sine_quarter_lut.sv
// Quarter-wave sine magnitude ROM: 64 entries of round(2047*sin(i*pi/126)), entry 0 = 0.
// Only present when DAC_WAVE_SINE_EN is defined.
`ifdef DAC_WAVE_SINE_EN
module sine_quarter_lut (
  input  logic [5:0]  i_index,
  output logic [10:0] o_mag
);
  localparam logic [10:0] QUARTER [64] = '{
    11'd0,    11'd51,   11'd102,  11'd153,  11'd204,  11'd255,  11'd305,  11'd355,
    11'd406,  11'd455,  11'd505,  11'd554,  11'd603,  11'd652,  11'd700,  11'd748,
    11'd795,  11'd842,  11'd888,  11'd934,  11'd979,  11'd1024, 11'd1067, 11'd1111,
    11'd1153, 11'd1195, 11'd1236, 11'd1276, 11'd1316, 11'd1354, 11'd1392, 11'd1429,
    11'd1465, 11'd1501, 11'd1535, 11'd1568, 11'd1600, 11'd1632, 11'd1662, 11'd1691,
    11'd1720, 11'd1747, 11'd1773, 11'd1798, 11'd1822, 11'd1844, 11'd1866, 11'd1886,
    11'd1906, 11'd1924, 11'd1940, 11'd1956, 11'd1970, 11'd1984, 11'd1996, 11'd2006,
    11'd2016, 11'd2024, 11'd2031, 11'd2037, 11'd2041, 11'd2044, 11'd2046, 11'd2047
  };

  assign o_mag = QUARTER[i_index];
endmodule
`endif

// File: rtl/dac_wave_gen.sv
// Tick-paced waveform generator driving a DAC interface through an update/busy handshake.
// Define DAC_WAVE_SINE_EN to turn wave_sel=11 into a sine; otherwise it outputs midscale.
module dac_wave_gen
  import dac_wave_gen_pkg::*;
#(
  parameter int ACK_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  wave_sel,
  input  logic [11:0] step,
  input  logic [15:0] period,
  input  logic        busy,
  output logic [11:0] value,
  output logic        update,
  output logic [7:0]  overrun,
  output logic        active
);

  localparam int ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  logic [2:0]       r_state;
  logic [15:0]      r_cnt;
  logic [11:0]      r_phase;
  logic [11:0]      r_value;
  logic [7:0]       r_overrun;
  logic [ACK_W-1:0] r_ack_cnt;

  logic        w_tick;
  logic        w_in_xfer;
  logic [11:0] w_phase_inc;
  logic [11:0] w_sine;
  logic [11:0] w_wave;

  // >= rather than == so a live shrink of period below the running count still ticks.
  assign w_tick      = enable && (r_cnt >= period);
  assign w_in_xfer   = (r_state == ST_PULSE) || (r_state == ST_ACK) || (r_state == ST_HOLD);
  assign w_phase_inc = r_phase + step;

`ifdef DAC_WAVE_SINE_EN
  logic [5:0]  w_lut_idx;
  logic [10:0] w_lut_mag;

  assign w_lut_idx = w_phase_inc[10] ? ~w_phase_inc[9:4] : w_phase_inc[9:4];

  sine_quarter_lut u_sine_lut (
    .i_index (w_lut_idx),
    .o_mag   (w_lut_mag)
  );

  assign w_sine = w_phase_inc[11] ? (MIDSCALE - {1'b0, w_lut_mag})
                                  : (MIDSCALE + {1'b0, w_lut_mag});
`else
  assign w_sine = MIDSCALE;
`endif

  assign w_wave = wave_map(wave_sel, w_phase_inc, w_sine);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!enable || w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_phase   <= '0;
      r_value   <= '0;
      r_overrun <= '0;
      r_ack_cnt <= '0;
    end else begin
      // Phase keeps moving on dropped ticks so the waveform frequency stays exact.
      if (w_tick && (r_state != ST_IDLE)) begin
        r_phase <= w_phase_inc;
      end
      if (w_tick && w_in_xfer && (r_overrun != 8'hFF)) begin
        r_overrun <= r_overrun + 8'd1;
      end
      case (r_state)
        ST_IDLE: begin
          if (enable) r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!enable) begin
            r_state <= ST_IDLE;
          end else if (w_tick) begin
            r_state <= ST_PULSE;
            r_value <= w_wave;
          end
        end
        ST_PULSE: begin
          r_state   <= ST_ACK;
          r_ack_cnt <= '0;
        end
        ST_ACK: begin
          if (busy) begin
            r_state <= ST_HOLD;
          end else if (r_ack_cnt == ACK_W'(ACK_TIMEOUT - 1)) begin
            r_state <= ST_WAIT;
          end else begin
            r_ack_cnt <= r_ack_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (!busy) r_state <= enable ? ST_WAIT : ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign value   = r_value;
  assign update  = (r_state == ST_PULSE);
  assign overrun = r_overrun;
  assign active  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dac_wave_gen.sv
// Self-checking bench for dac_wave_gen: table-driven waveform runs plus hand-written
// sequences for overrun saturation, ACK timeout, enable drop in HOLD and reset in PULSE.
`timescale 1ns/1ps
module tb_dac_wave_gen;
  import dac_wave_gen_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  wave_sel = 2'b00;
  logic [11:0] step = 12'd0;
  logic [15:0] period = 16'd0;
  logic        busy = 1'b0;
  logic [11:0] value;
  logic        update;
  logic [7:0]  overrun;
  logic        active;

  dac_wave_gen #(.ACK_TIMEOUT(15)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .wave_sel (wave_sel),
    .step     (step),
    .period   (period),
    .busy     (busy),
    .value    (value),
    .update   (update),
    .overrun  (overrun),
    .active   (active)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Busy model: after seeing update, hold busy high for busy_len clocks.
  int busy_len = 3;
  initial begin
    forever begin
      @(negedge clk);
      if (update === 1'b1 && busy_len > 0) begin
        busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        busy = 1'b0;
      end
    end
  end

  // Scoreboard: expected values queued by the stimulus, popped on each update pulse.
  logic [11:0] exp_q[$];
  bit sb_on = 0;
  int exp_gap = 0;
  int upd_count = 0;
  int last_cyc = -1;
  initial begin
    forever begin
      @(negedge clk);
      if (update === 1'b1) begin
        upd_count++;
        if (sb_on) begin
          if (exp_q.size() == 0) chk("unexpected_update", 1, 0);
          else chk("value", int'(value), int'(exp_q.pop_front()));
          if (exp_gap > 0 && last_cyc >= 0) chk("update_gap", cyc - last_cyc, exp_gap);
        end
        last_cyc = cyc;
      end
    end
  end

  function automatic logic [11:0] ref_wave(input logic [1:0] sel, input int ph);
    logic [11:0] r;
    case (sel)
      2'b00: r = 12'(ph);
      2'b01: r = (ph < 2048) ? 12'(2 * ph) : 12'(4095 - 2 * (ph - 2048));
      2'b10: r = (ph < 2048) ? 12'h000 : 12'hFFF;
      default: begin
`ifdef DAC_WAVE_SINE_EN
        if (ph == 1024) r = 12'hFFF;
        else if (ph == 3072) r = 12'h001;
        else r = 12'h800;
`else
        r = 12'h800;
`endif
      end
    endcase
    return r;
  endfunction

  task automatic do_reset();
    enable = 1'b0;
    for (int i = 0; i < 60 && busy; i++) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    last_cyc = -1;
  endtask

  task automatic wait_upd(input int budget, input string name, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (update === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk({name, "_timeout"}, 0, 1);
  endtask

  typedef struct {
    logic [1:0]  sel;
    logic [11:0] stp;
    logic [15:0] per;
    int          blen;
    int          n;
    int          tpu;     // ticks per accepted update
    int          gap;     // expected clocks between updates
    int          ovr;     // expected overrun after n updates
  } vec_t;

  vec_t vt[5];

  initial begin
    bit ok;
    int c0, c1, acc, expv, ucnt, ph;

    vt[0] = '{WAVE_SAW,  12'd256,  16'd9, 3, 16, 1, 10, 0};
    vt[1] = '{WAVE_TRI,  12'd1024, 16'd9, 3, 8,  1, 10, 0};
    vt[2] = '{WAVE_SQR,  12'd512,  16'd4, 3, 8,  1, 5,  0};
    vt[3] = '{WAVE_SINE, 12'd1024, 16'd9, 3, 8,  1, 10, 0};
    vt[4] = '{WAVE_SAW,  12'd100,  16'd2, 3, 10, 2, 6,  9};

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_value", int'(value), 0);
    chk("rst_update", int'(update), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_active", int'(active), 0);

    // Table-driven waveform runs
    for (int r = 0; r < 5; r++) begin
      do_reset();
      wave_sel = vt[r].sel;
      step     = vt[r].stp;
      period   = vt[r].per;
      busy_len = vt[r].blen;
      exp_gap  = vt[r].gap;
      for (int k = 0; k < vt[r].n; k++) begin
        ph = (int'(vt[r].stp) * (1 + k * vt[r].tpu)) % 4096;
        exp_q.push_back(ref_wave(vt[r].sel, ph));
      end
      sb_on  = 1;
      enable = 1'b1;
      for (int i = 0; i < 3000 && exp_q.size() > 0; i++) @(negedge clk);
      chk("row_updates_done", exp_q.size(), 0);
      chk("row_overrun", int'(overrun), vt[r].ovr);
      chk("row_active", int'(active), 1);
      sb_on = 0;
      exp_q.delete();
    end

    // Overrun saturation: tick every clock, 20-clock busy per transaction
    do_reset();
    wave_sel = WAVE_SAW; step = 12'd5; period = 16'd0; busy_len = 20;
    enable = 1'b1;
    acc = 0; expv = 0; c0 = 0;
    for (int k = 0; k < 16; k++) begin
      wait_upd(60, "sat_upd", ok);
      if (!ok) break;
      c1 = cyc;
      if (k == 0) expv = 5;
      else begin
        expv = (expv + 5 * (c1 - c0)) % 4096;
        acc  = acc + (c1 - c0 - 1);
      end
      chk("sat_value", int'(value), expv);
      chk("sat_overrun", int'(overrun), (acc > 255) ? 255 : acc);
      c0 = c1;
    end
    chk("sat_final", int'(overrun), 255);

    // Reset asserted while in PULSE
    wait_upd(60, "rst_pulse_upd", ok);
    rst = 1'b1;
    @(negedge clk);
    chk("rstp_update", int'(update), 0);
    chk("rstp_value", int'(value), 0);
    chk("rstp_active", int'(active), 0);
    chk("rstp_overrun", int'(overrun), 0);
    rst = 1'b0;

    // ACK timeout with busy never asserted
    do_reset();
    wave_sel = WAVE_SAW; step = 12'd16; period = 16'd16; busy_len = 0;
    enable = 1'b1;
    wait_upd(40, "to_upd0", ok);
    chk("to_value0", int'(value), 16);
    c0 = cyc;
    wait_upd(40, "to_upd1", ok);
    chk("to_gap_after_timeout", cyc - c0, 17);
    chk("to_value1", int'(value), 32);
    chk("to_overrun0", int'(overrun), 0);
    c0 = cyc;
    period = 16'd15;
    wait_upd(60, "to_upd2", ok);
    chk("to_gap_dropped", cyc - c0, 32);
    chk("to_value2", int'(value), 64);
    chk("to_overrun1", int'(overrun), 1);

    // Enable cleared while in HOLD
    do_reset();
    wave_sel = WAVE_SAW; step = 12'd7; period = 16'd9; busy_len = 5;
    enable = 1'b1;
    wait_upd(30, "hold_upd", ok);
    chk("hold_value", int'(value), 7);
    repeat (2) @(negedge clk);
    enable = 1'b0;
    ucnt = upd_count;
    repeat (3) @(negedge clk);
    chk("hold_active_busy", int'(active), 1);
    @(negedge clk);
    chk("hold_active_fell", int'(active), 0);
    repeat (30) @(negedge clk);
    chk("hold_no_update", upd_count - ucnt, 0);
    chk("hold_value_kept", int'(value), 7);
    chk("hold_overrun", int'(overrun), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dac_wave_gen.md
DAC_WAVE_GEN -- requirements
Module: dac_wave_gen

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 15, meaning the number of clocks to wait for busy to rise after an update pulse.
REQ-002 SHALL have port clk, input, 1, system clock; all logic on the rising edge.
REQ-003 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port enable, input, 1, run/stop sample generation.
REQ-005 SHALL have port wave_sel, input, 2, waveform select: 00 saw, 01 triangle, 10 square, 11 sine/midscale.
REQ-006 SHALL have port step, input, 12, phase increment per sample tick.
REQ-007 SHALL have port period, input, 16, sample interval minus one, in clk cycles.
REQ-008 SHALL have port busy, input, 1, DAC interface transaction in progress.
REQ-009 SHALL have port value, output, 12, DAC code fed to the DAC interface data input.
REQ-010 SHALL have port update, output, 1, one-cycle request pulse to the DAC interface.
REQ-011 SHALL have port overrun, output, 8, saturating count of dropped samples.
REQ-012 SHALL have port active, output, 1, high when the FSM is not in IDLE.

Function
REQ-013 SHALL count clk cycles 0..period and raise an internal tick when count==period, then restart at 0; period=0 ticks every cycle.
REQ-014 SHALL run the tick counter and hold it at 0 while enable=0.
REQ-015 SHALL advance a 12-bit phase by step on every tick, modulo 4096, including ticks that are dropped.
REQ-016 SHALL map waveforms from the phase as follows: saw = phase; triangle = phase[11] ? ~{phase[10:0],0} : {phase[10:0],0}; square = phase[11] ? 12'hFFF : 12'h000.
REQ-017 SHALL use the FSM states IDLE, WAIT, PULSE, ACK, HOLD.
REQ-018 SHALL transition IDLE->WAIT when enable=1.
REQ-019 SHALL transition WAIT->PULSE on a tick, registering value from the post-increment phase on the same edge.
REQ-020 SHALL assert update for exactly the one cycle spent in PULSE, then go to ACK.
REQ-021 SHALL transition ACK->HOLD when busy=1, or ACK->WAIT after ACK_TIMEOUT clocks without busy.
REQ-022 SHALL transition HOLD->WAIT, or HOLD->IDLE if enable=0, when busy=0.
REQ-023 SHALL hold value stable from PULSE until the next WAIT->PULSE transition.
REQ-024 SHALL count a tick occurring in PULSE, ACK or HOLD as dropped: overrun increments and saturates at 255, and value is not updated.
REQ-025 SHALL let enable=0 in WAIT go to IDLE next cycle, and let enable=0 in PULSE/ACK/HOLD finish the transaction before IDLE; phase is held in IDLE.
REQ-026 SHALL sample wave_sel, step and period live, with changes taking effect at the next tick.

Reset
REQ-027 SHALL put the FSM in IDLE on rst=1 and clear phase, tick counter, value (12'h000), update (0), overrun (0) and active (0).
REQ-028 SHALL let rst override any state including a PULSE in progress, with update low in the cycle after rst is sampled.

Configuration
REQ-029 SHALL select, with macro DAC_WAVE_SINE_EN defined, wave_sel=11 as sine: a 64-entry quarter-wave table indexed by phase[9:4], mirrored by phase[10] and inverted about 12'h800 by phase[11], with entry 0 = 12'h800.
REQ-030 SHALL output a constant 12'h800 for wave_sel=11 without DAC_WAVE_SINE_EN, and compile no table logic.

Structure
REQ-031 SHALL define the FSM state encoding and the waveform select codes (WAVE_SAW, WAVE_TRI, WAVE_SQR, WAVE_SINE) in the shared package.
REQ-032 SHALL place the sine table in sub-module sine_quarter_lut (6-bit index in, 11-bit magnitude out), instantiated only under DAC_WAVE_SINE_EN.

Verification
REQ-033 SHALL cover: saw, step=256, period=9, busy model 3 clocks -> update every 10 clocks, value 256, 512, ..., 3840, 0; overrun=0.
REQ-034 SHALL cover: triangle, step=1024 -> value sequence 2048, 4095 (from ~0), 2047, 0 repeating.
REQ-035 SHALL cover: period=0 with busy held 20 clocks per transaction -> dropped ticks raise overrun to 255 and it stays there; phase still advances by step every clock.
REQ-036 SHALL cover: busy never asserts -> update pulse, ACK times out after 15 clocks, FSM returns to WAIT, next tick pulses again.
REQ-037 SHALL cover: enable cleared while in HOLD -> no further update, active falls one cycle after busy falls; rst asserted in PULSE -> next cycle update=0, value=0, active=0.
REQ-038 SHALL cover: wave_sel=11, step=1024 -> with DAC_WAVE_SINE_EN value 12'hFFF-region peak at phase 1024 and 12'h800 at phase 2048; without the macro, constant 12'h800.
